// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//
// Shares a single toggle-handshake SDRAM ROM channel between several video
// chip ROM fetchers (pivot layer, sprite, tilemap). Each requester flips its
// req_toggle bit, holds its address, and waits until its req_ack bit matches.
// The arbiter picks one pending requester, forwards its address to the SDRAM
// channel by flipping sdr_req, waits for sdr_ack to match, and then returns
// the data and the ack to that requester only.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   req_addr    packed requester addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_toggle  requester request toggles
//   req_ack     requester ack toggles (equal to req_toggle when served)
//   req_data    packed last data returned, requester i at [i*DATA_W +: DATA_W]
//   sdr_addr    address presented to the SDRAM channel
//   sdr_req     SDRAM channel request toggle
//   sdr_ack     SDRAM channel ack toggle, equals sdr_req when done
//   sdr_data    SDRAM read data, valid when sdr_ack becomes equal to sdr_req
//   busy        high while a channel transaction is outstanding
//   grant_idx   index of the current or last granted requester

module rom_port_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 16,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_toggle,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [ADDR_W-1:0]         sdr_addr,
    output logic                      sdr_req,
    input  logic                      sdr_ack,
    input  logic [DATA_W-1:0]         sdr_data,
    output logic                      busy,
    output logic [2:0]                grant_idx
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [NUM_REQ-1:0]  pend;
    logic [2:0]          rr_ptr;
    logic                tog_lat;
    logic                grant_valid;
    logic [2:0]          grant_sel;
    logic [ADDR_W-1:0]   grant_addr;
    logic                grant_tog;
    logic                issue;
    logic                complete;

    // A requester is pending while its toggle differs from the ack we hold.
    assign pend = req_toggle ^ req_ack;

    // Grant selection. Round-robin is done as two ascending passes: first the
    // indices above the last grant, then everything from zero, which gives
    // the first pending index from ptr+1 upward with wrap.
    always_comb begin : grant_select
        grant_valid = 1'b0;
        grant_sel   = '0;
        if (ROUND_ROBIN != 0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_valid && pend[i] && (i > int'(rr_ptr))) begin
                    grant_valid = 1'b1;
                    grant_sel   = 3'(i);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && pend[i]) begin
                grant_valid = 1'b1;
                grant_sel   = 3'(i);
            end
        end
    end

    // Address and toggle of the selected requester.
    always_comb begin : grant_mux
        grant_addr = '0;
        grant_tog  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == grant_sel) begin
                grant_addr = req_addr[i*ADDR_W +: ADDR_W];
                grant_tog  = req_toggle[i];
            end
        end
    end

    // Next-state logic. Issue also waits for the channel to be idle, so a
    // stale ack left over from reset blocks new requests until it settles.
    always_comb begin : fsm_next
        next_state = state;
        issue      = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid && (sdr_ack == sdr_req)) begin
                    issue      = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (sdr_ack == sdr_req) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin : fsm_state
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Channel and requester registers. The toggle is latched at grant time so
    // a requester that toggles again mid-transaction stays pending and is
    // served once more instead of being lost.
    always_ff @(posedge clk or posedge reset) begin : datapath
        if (reset) begin
            sdr_addr  <= '0;
            sdr_req   <= 1'b0;
            tog_lat   <= 1'b0;
            grant_idx <= '0;
            busy      <= 1'b0;
            req_ack   <= '0;
            req_data  <= '0;
            rr_ptr    <= 3'(NUM_REQ - 1);
        end else if (issue) begin
            sdr_addr  <= grant_addr;
            sdr_req   <= ~sdr_req;
            tog_lat   <= grant_tog;
            grant_idx <= grant_sel;
            busy      <= 1'b1;
        end else if (complete) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (3'(i) == grant_idx) begin
                    req_data[i*DATA_W +: DATA_W] <= sdr_data;
                    req_ack[i]                   <= tog_lat;
                end
            end
            busy <= 1'b0;
            if (ROUND_ROBIN != 0) begin
                rr_ptr <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter
//
// Bench for rom_port_arbiter with four requesters and round-robin grant.
// A small SDRAM channel model answers requests after a programmable latency
// with data derived from the address. Expected grants are queued when a
// requester is toggled and compared when the arbiter flips sdr_req; the
// matching ack and data are compared when req_ack changes.

module tb_rom_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 27;
    localparam int DATA_W  = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_toggle;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [ADDR_W-1:0]         sdr_addr;
    logic                      sdr_req;
    logic                      sdr_ack;
    logic [DATA_W-1:0]         sdr_data;
    logic                      busy;
    logic [2:0]                grant_idx;

    typedef struct {
        int                idx;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              tog;
    } txn_t;

    txn_t exp_q[$];
    txn_t act_q[$];
    int   flip_cycles[$];

    int   checks     = 0;
    int   errors     = 0;
    int   cycle      = 0;
    int   flip_count = 0;
    bit   chan_en    = 1'b1;
    int   chan_lat   = 0;
    int   chan_cnt   = 0;

    logic [ADDR_W-1:0] slot_addr [NUM_REQ];
    logic [5:0]        busy_bits;

    rom_port_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ROUND_ROBIN(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_addr  (req_addr),
        .req_toggle(req_toggle),
        .req_ack   (req_ack),
        .req_data  (req_data),
        .sdr_addr  (sdr_addr),
        .sdr_req   (sdr_req),
        .sdr_ack   (sdr_ack),
        .sdr_data  (sdr_data),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    // Data the channel returns for an address.
    function automatic logic [DATA_W-1:0] model_data(input logic [ADDR_W-1:0] a);
        if (a == 27'h0123456) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic expectGrant(input int idx, input logic tog);
        txn_t e;
        e.idx  = idx;
        e.addr = slot_addr[idx];
        e.data = model_data(slot_addr[idx]);
        e.tog  = tog;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] mask);
        req_toggle = req_toggle ^ mask;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset      = 1'b1;
        req_toggle = '0;
        sdr_ack    = 1'b0;
        chan_en    = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        act_q.delete();
        reset = 1'b0;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && act_q.size() == 0 && !busy) done = 1'b1;
        end
        checkOutput(tag, 64'(done), 64'd1);
    endtask

    // SDRAM channel model: answers an outstanding toggle after chan_lat clocks.
    initial begin : channel
        forever begin
            @(posedge clk);
            #1;
            if (reset || !chan_en) begin
                chan_cnt = 0;
            end else if (sdr_ack != sdr_req) begin
                if (chan_cnt >= chan_lat) begin
                    sdr_data = model_data(sdr_addr);
                    sdr_ack  = sdr_req;
                    chan_cnt = 0;
                end else begin
                    chan_cnt++;
                end
            end
        end
    end

    // Scoreboard monitor: grants and acks are compared against queued entries.
    initial begin : monitor
        logic               prev_req;
        logic [NUM_REQ-1:0] prev_ack;
        txn_t               e;
        prev_req = 1'b0;
        prev_ack = '0;
        forever begin
            @(negedge clk);
            cycle++;
            if (reset) begin
                prev_req = sdr_req;
                prev_ack = req_ack;
            end else begin
                if (sdr_req !== prev_req) begin
                    flip_count++;
                    flip_cycles.push_back(cycle);
                    checkOutput("busy_on_grant", 64'(busy), 64'd1);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_grant", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("grant_idx", 64'(grant_idx), 64'(e.idx));
                        checkOutput("sdr_addr", 64'(sdr_addr), 64'(e.addr));
                        act_q.push_back(e);
                    end
                    prev_req = sdr_req;
                end
                if (req_ack !== prev_ack) begin
                    if (act_q.size() == 0) begin
                        checkOutput("unexpected_ack", 64'd1, 64'd0);
                    end else begin
                        e = act_q.pop_front();
                        checkOutput("ack_bits", 64'(req_ack ^ prev_ack), 64'd1 << e.idx);
                        checkOutput("ack_value", 64'(req_ack[e.idx]), 64'(e.tog));
                        checkOutput("req_data", 64'(req_data[e.idx*DATA_W +: DATA_W]),
                                    64'(e.data));
                        checkOutput("busy_on_ack", 64'(busy), 64'd0);
                    end
                    prev_ack = req_ack;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        reset      = 1'b1;
        req_toggle = '0;
        sdr_ack    = 1'b0;
        sdr_data   = '0;
        slot_addr[0] = 27'h0000A10;
        slot_addr[1] = 27'h1ABCDE0;
        slot_addr[2] = 27'h0123456;
        slot_addr[3] = 27'h7FFFFFE;
        for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = slot_addr[i];

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ack", 64'(req_ack), 64'd0);
        checkOutput("rst_req_data", 64'(req_data), 64'd0);
        checkOutput("rst_sdr_addr", 64'(sdr_addr), 64'd0);
        checkOutput("rst_sdr_req", 64'(sdr_req), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_grant_idx", 64'(grant_idx), 64'd0);
        reset = 1'b0;

        // Single request on port 2
        $display("[TB] single request");
        chan_lat   = 5;
        flip_count = 0;
        expectGrant(2, 1'b1);
        @(negedge clk);
        applyStimulus(4'b0100);
        waitDrain("t1_drain", 50);
        checkOutput("t1_acks", 64'(req_ack), 64'h4);
        checkOutput("t1_flips", 64'(flip_count), 64'd1);
        checkOutput("t1_sdr_addr", 64'(sdr_addr), 64'h0123456);

        // Round-robin fairness, two rounds from a fresh pointer
        $display("[TB] round robin");
        applyReset();
        chan_lat   = 3;
        flip_count = 0;
        for (int i = 0; i < NUM_REQ; i++) expectGrant(i, 1'b1);
        @(negedge clk);
        applyStimulus(4'b1111);
        waitDrain("t2_drain_a", 100);
        checkOutput("t2_acks_a", 64'(req_ack), 64'hF);
        for (int i = 0; i < NUM_REQ; i++) expectGrant(i, 1'b0);
        @(negedge clk);
        applyStimulus(4'b1111);
        waitDrain("t2_drain_b", 100);
        checkOutput("t2_acks_b", 64'(req_ack), 64'h0);
        checkOutput("t2_flips", 64'(flip_count), 64'd8);

        // Back-to-back with a zero-latency channel
        $display("[TB] back to back");
        chan_lat   = 0;
        flip_count = 0;
        flip_cycles.delete();
        expectGrant(1, 1'b1);
        expectGrant(2, 1'b1);
        expectGrant(3, 1'b1);
        @(negedge clk);
        applyStimulus(4'b1110);
        busy_bits = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            busy_bits = {busy_bits[4:0], busy};
        end
        checkOutput("t3_busy_wave", 64'(busy_bits), 64'b101010);
        waitDrain("t3_drain", 50);
        checkOutput("t3_flips", 64'(flip_cycles.size()), 64'd3);
        if (flip_cycles.size() == 3) begin
            checkOutput("t3_gap_a", 64'(flip_cycles[1] - flip_cycles[0]), 64'd2);
            checkOutput("t3_gap_b", 64'(flip_cycles[2] - flip_cycles[1]), 64'd2);
        end

        // Double toggle while granted
        $display("[TB] double toggle");
        applyReset();
        chan_lat   = 4;
        flip_count = 0;
        expectGrant(3, 1'b1);
        expectGrant(3, 1'b0);
        @(negedge clk);
        applyStimulus(4'b1000);
        @(negedge clk);
        checkOutput("t4_busy", 64'(busy), 64'd1);
        applyStimulus(4'b1000);
        waitDrain("t4_drain", 100);
        checkOutput("t4_acks", 64'(req_ack), 64'h0);
        checkOutput("t4_flips", 64'(flip_count), 64'd2);

        // Asynchronous reset while waiting on the channel
        $display("[TB] async reset in wait");
        chan_lat = 2;
        expectGrant(1, 1'b1);
        expectGrant(2, 1'b1);
        @(negedge clk);
        applyStimulus(4'b0110);
        waitDrain("t5_drain_pre", 50);
        checkOutput("t5_acks_pre", 64'(req_ack), 64'h6);
        chan_lat = 20;
        expectGrant(0, 1'b1);
        @(negedge clk);
        applyStimulus(4'b0001);
        @(negedge clk);
        checkOutput("t5_busy_pre", 64'(busy), 64'd1);
        checkOutput("t5_sdr_req_pre", 64'(sdr_req), 64'd1);
        @(posedge clk);
        #3;
        reset   = 1'b1;
        sdr_ack = 1'b0;
        #1;
        checkOutput("t5_async_busy", 64'(busy), 64'd0);
        checkOutput("t5_async_sdr_req", 64'(sdr_req), 64'd0);
        checkOutput("t5_async_req_ack", 64'(req_ack), 64'd0);
        req_toggle = 4'b0001;
        chan_lat   = 2;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        act_q.delete();
        expectGrant(0, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_regrant_busy", 64'(busy), 64'd1);
        checkOutput("t5_regrant_idx", 64'(grant_idx), 64'd0);
        waitDrain("t5_drain_post", 50);
        checkOutput("t5_acks_post", 64'(req_ack), 64'h1);

        // Stale channel ack after reset blocks issue
        $display("[TB] stale ack");
        @(negedge clk);
        reset      = 1'b1;
        req_toggle = '0;
        chan_en    = 1'b0;
        sdr_ack    = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        act_q.delete();
        reset = 1'b0;
        applyStimulus(4'b0001);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t6_stale_sdr_req", 64'(sdr_req), 64'd0);
            checkOutput("t6_stale_busy", 64'(busy), 64'd0);
        end
        expectGrant(0, 1'b1);
        sdr_ack = 1'b0;
        chan_en = 1'b1;
        waitDrain("t6_drain", 50);
        checkOutput("t6_acks", 64'(req_ack), 64'h1);
        checkOutput("t6_sdr_req", 64'(sdr_req), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
